// File: rtl/dma_pkg.sv
// Shared DMA types: read-streamer state encoding, error report record and
// the 4 KiB burst boundary helper.
package dma_pkg;

    localparam int DMA_ADDR_W      = 32;
    localparam int DMA_4K_BOUNDARY = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } dma_rd_st_t;

    typedef enum logic [1:0] {
        DMA_ERR_NONE = 2'd0,
        DMA_ERR_RD   = 2'd1,
        DMA_ERR_WR   = 2'd2,
        DMA_ERR_DESC = 2'd3
    } dma_err_src_t;

    typedef struct packed {
        logic                  valid;
        dma_err_src_t          src;
        logic [DMA_ADDR_W-1:0] addr;
    } s_dma_error_t;

    // Bytes from an address offset (within a 4 KiB page) to the next page start.
    function automatic logic [12:0] bytes_to_boundary(input logic [11:0] page_off);
        return 13'(DMA_4K_BOUNDARY) - {1'b0, page_off};
    endfunction

endpackage

// File: rtl/dma_len_fifo.sv
// Small synchronous FIFO holding the beat count of each outstanding burst.
// An empty FIFO with push and pop in the same cycle passes the data through.
module dma_len_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;
    logic             bypass;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign bypass   = empty & push & pop;
    assign do_push  = push & (~full | pop) & ~bypass;
    assign do_pop   = pop & ~empty;
    assign pop_data = empty ? push_data : mem[rd_ptr];

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_rd_streamer.sv
// Read-side DMA streamer: splits a descriptor into AXI read bursts (capped by
// MAX_BURST_LEN and 4 KiB pages), limits outstanding bursts, counts in-order
// responses and reports done plus the first error back to the control FSM.
// Optional performance counters: define DMA_RD_STREAMER_PERF_EN.
module dma_rd_streamer
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int BYTES_WIDTH     = 32,
    parameter int BUS_BYTES       = 8,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stream_valid_i,
    input  logic [ADDR_WIDTH-1:0]  desc_src_addr_i,
    input  logic [BYTES_WIDTH-1:0] desc_num_bytes_i,
    output logic                   stream_done_o,
    output s_dma_error_t           stream_err_o,
    output logic                   req_valid_o,
    input  logic                   req_ready_i,
    output logic [ADDR_WIDTH-1:0]  req_addr_o,
    output logic [7:0]             req_len_o,
    output logic [2:0]             req_size_o,
    input  logic                   rsp_valid_i,
    input  logic                   rsp_err_i
`ifdef DMA_RD_STREAMER_PERF_EN
    ,
    output logic [31:0]            perf_bursts_o,
    output logic [31:0]            perf_stall_o
`endif
);

    localparam int SIZE_LOG2 = $clog2(BUS_BYTES);
    localparam int OUT_W     = $clog2(MAX_OUTSTANDING) + 1;

    dma_rd_st_t             state;
    dma_rd_st_t             state_nxt;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [ADDR_WIDTH-1:0]  rsp_addr;
    logic [BYTES_WIDTH-1:0] rem_beats;
    logic [OUT_W-1:0]       outstanding;
    logic                   err_seen;
    logic                   done_seen;
    logic [12:0]            beats_to_4k;
    logic [8:0]             burst_beats;
    logic [8:0]             pop_beats;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   misaligned;
    logic                   req_fire;
    logic                   rsp_active;
    logic                   rsp_err_new;
    logic                   start;

    assign start       = (state == ST_IDLE) & stream_valid_i;
    assign misaligned  = ((desc_src_addr_i & ADDR_WIDTH'(BUS_BYTES - 1)) != '0) |
                         ((desc_num_bytes_i & BYTES_WIDTH'(BUS_BYTES - 1)) != '0);
    assign beats_to_4k = bytes_to_boundary(cur_addr[11:0]) >> SIZE_LOG2;
    assign req_valid_o = (state == ST_ISSUE) & (outstanding < OUT_W'(MAX_OUTSTANDING)) & ~fifo_full;
    assign req_fire    = req_valid_o & req_ready_i;
    assign rsp_active  = ((state == ST_CHECK) | (state == ST_ISSUE) | (state == ST_DRAIN)) &
                         rsp_valid_i & (outstanding != '0) & ~fifo_empty;
    assign rsp_err_new = rsp_active & rsp_err_i & ~err_seen;

    assign req_addr_o    = (state == ST_ISSUE) ? cur_addr : '0;
    assign req_len_o     = (state == ST_ISSUE) ? 8'(burst_beats - 9'd1) : '0;
    assign req_size_o    = 3'(SIZE_LOG2);
    assign stream_done_o = (state == ST_DONE) & ~done_seen;

    // Burst size: smallest of remaining beats, burst cap and beats left in the page.
    always_comb begin
        logic [BYTES_WIDTH-1:0] b;
        b = BYTES_WIDTH'(MAX_BURST_LEN);
        if (BYTES_WIDTH'(beats_to_4k) < b) b = BYTES_WIDTH'(beats_to_4k);
        if (rem_beats < b)                 b = rem_beats;
        burst_beats = 9'(b);
    end

    // First-error report: alignment fault in CHECK, or first failing burst response.
    always_comb begin
        stream_err_o = '0;
        if ((state == ST_CHECK) && misaligned) begin
            stream_err_o.valid = 1'b1;
            stream_err_o.src   = DMA_ERR_RD;
            stream_err_o.addr  = DMA_ADDR_W'(desc_src_addr_i);
        end else if (rsp_err_new) begin
            stream_err_o.valid = 1'b1;
            stream_err_o.src   = DMA_ERR_RD;
            stream_err_o.addr  = DMA_ADDR_W'(rsp_addr);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (stream_valid_i) state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (misaligned || (desc_num_bytes_i == '0)) state_nxt = ST_DONE;
                else                                        state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (rsp_active && rsp_err_i)                                 state_nxt = ST_DRAIN;
                else if (req_fire && (rem_beats == BYTES_WIDTH'(burst_beats))) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (outstanding == '0) state_nxt = ST_DONE;
            ST_DONE:  if (!stream_valid_i)   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Control state, beat and outstanding counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rem_beats   <= '0;
            outstanding <= '0;
            err_seen    <= 1'b0;
            done_seen   <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_seen <= (state == ST_DONE);
            if (start) begin
                rem_beats <= desc_num_bytes_i >> SIZE_LOG2;
                err_seen  <= 1'b0;
            end else begin
                if (req_fire)    rem_beats <= rem_beats - BYTES_WIDTH'(burst_beats);
                if (rsp_err_new) err_seen  <= 1'b1;
            end
            case ({req_fire, rsp_active})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Request and response address tracking (data path, not reset).
    always_ff @(posedge clk) begin
        if (start) begin
            cur_addr <= desc_src_addr_i;
            rsp_addr <= desc_src_addr_i;
        end else begin
            if (req_fire)   cur_addr <= cur_addr + (ADDR_WIDTH'(burst_beats) << SIZE_LOG2);
            if (rsp_active) rsp_addr <= rsp_addr + (ADDR_WIDTH'(pop_beats) << SIZE_LOG2);
        end
    end

    dma_len_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (9)
    ) u_len_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (burst_beats),
        .pop       (rsp_active),
        .pop_data  (pop_beats),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef DMA_RD_STREAMER_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Burst and stall counters, restarted for every descriptor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bursts_o <= '0;
            perf_stall_o  <= '0;
        end else if (start) begin
            perf_bursts_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (req_fire)                   perf_bursts_o <= sat_inc(perf_bursts_o);
            if (req_valid_o & ~req_ready_i) perf_stall_o  <= sat_inc(perf_stall_o);
        end
    end
`endif

endmodule

// File: tb/tb_dma_rd_streamer.sv
// Self-checking bench for dma_rd_streamer: table of descriptors with a burst
// scoreboard, plus hand-written outstanding-cap/error and reset sequences.
module tb_dma_rd_streamer;
    import dma_pkg::*;

    logic         clk;
    logic         rst;
    logic         stream_valid_i;
    logic [31:0]  desc_src_addr_i;
    logic [31:0]  desc_num_bytes_i;
    logic         stream_done_o;
    s_dma_error_t stream_err_o;
    logic         req_valid_o;
    logic         req_ready_i;
    logic [31:0]  req_addr_o;
    logic [7:0]   req_len_o;
    logic [2:0]   req_size_o;
    logic         rsp_valid_i;
    logic         rsp_err_i;
`ifdef DMA_RD_STREAMER_PERF_EN
    logic [31:0]  perf_bursts;
    logic [31:0]  perf_stall;
`endif

    dma_rd_streamer dut (
        .clk              (clk),
        .rst              (rst),
        .stream_valid_i   (stream_valid_i),
        .desc_src_addr_i  (desc_src_addr_i),
        .desc_num_bytes_i (desc_num_bytes_i),
        .stream_done_o    (stream_done_o),
        .stream_err_o     (stream_err_o),
        .req_valid_o      (req_valid_o),
        .req_ready_i      (req_ready_i),
        .req_addr_o       (req_addr_o),
        .req_len_o        (req_len_o),
        .req_size_o       (req_size_o),
        .rsp_valid_i      (rsp_valid_i),
        .rsp_err_i        (rsp_err_i)
`ifdef DMA_RD_STREAMER_PERF_EN
        ,
        .perf_bursts_o    (perf_bursts),
        .perf_stall_o     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] src;
        logic [31:0] nbytes;
        int          exp_nreq;
        int          exp_first_len;
        int          exp_err;
        logic [31:0] exp_err_addr;
        int          exp_done_tick;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } req_t;

    req_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          nhs, nerr, ndone, done_tick, first_req_tick, tick_idx;
    int          pend_rsp, rsp_idx, err_rsp_at;
    int          first_len;
    logic [31:0] err_addr;
    logic        ready_val, rsp_hold;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_counters();
        nhs = 0; nerr = 0; ndone = 0; done_tick = -1; first_req_tick = -1;
        tick_idx = 0; pend_rsp = 0; rsp_idx = 0; first_len = -1; err_addr = '0;
    endtask

    // Reference split of a descriptor into bursts (16 beats max, no 4 KiB crossing).
    task automatic model_push(input logic [31:0] src, input logic [31:0] nbytes);
        logic [31:0] a;
        int unsigned rem, b, to4k;
        req_t r;
        a = src;
        rem = nbytes / 8;
        while (rem > 0) begin
            b = (rem > 16) ? 16 : rem;
            to4k = (4096 - (a % 4096)) / 8;
            if (b > to4k) b = to4k;
            r.addr = a;
            r.len  = 8'(b - 1);
            exp_q.push_back(r);
            a   = a + b * 8;
            rem = rem - b;
        end
    endtask

    // One clock: drive inputs at the falling edge, observe 1 ns later.
    task automatic tick();
        req_t r;
        req_ready_i = ready_val;
        if (!rsp_hold && pend_rsp > 0) begin
            rsp_valid_i = 1'b1;
            rsp_idx++;
            rsp_err_i = (rsp_idx == err_rsp_at);
        end else begin
            rsp_valid_i = 1'b0;
            rsp_err_i   = 1'b0;
        end
        #1;
        if (req_valid_o) begin
            if (first_req_tick < 0) first_req_tick = tick_idx;
            chk("req_size", req_size_o, 3);
            if (req_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req_addr", req_addr_o, 32'hFFFF_FFFF);
                end else begin
                    r = exp_q.pop_front();
                    chk("req_addr", req_addr_o, r.addr);
                    chk("req_len", req_len_o, r.len);
                end
                if (nhs == 0) first_len = int'(req_len_o);
                nhs++;
                pend_rsp++;
            end
        end
        if (rsp_valid_i) pend_rsp--;
        if (stream_err_o.valid) begin
            nerr++;
            err_addr = stream_err_o.addr;
            chk("err_src", stream_err_o.src, DMA_ERR_RD);
        end
        if (stream_done_o) begin
            ndone++;
            done_tick = tick_idx;
        end
        tick_idx++;
        @(negedge clk);
    endtask

    task automatic run_desc(input vec_t v, input string tag);
        reset_counters();
        ready_val = 1'b1; rsp_hold = 1'b0; err_rsp_at = -1;
        exp_q.delete();
        if (v.exp_err == 0) model_push(v.src, v.nbytes);
        desc_src_addr_i  = v.src;
        desc_num_bytes_i = v.nbytes;
        stream_valid_i   = 1'b1;
        for (int i = 0; i < 300 && ndone == 0; i++) tick();
        if (ndone == 0) chk({tag, "_done_timeout"}, 0, 1);
        repeat (3) tick();
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_req_count"}, nhs, v.exp_nreq);
        chk({tag, "_err_count"}, nerr, v.exp_err);
        if (v.exp_err != 0)      chk({tag, "_err_addr"}, err_addr, v.exp_err_addr);
        if (v.exp_done_tick >= 0) chk({tag, "_done_latency"}, done_tick, v.exp_done_tick);
        if (v.exp_nreq > 0) begin
            chk({tag, "_req_latency"}, first_req_tick, 2);
            chk({tag, "_first_len"}, first_len, v.exp_first_len);
        end
        chk({tag, "_scoreboard_left"}, exp_q.size(), 0);
`ifdef DMA_RD_STREAMER_PERF_EN
        chk({tag, "_perf_bursts"}, perf_bursts, v.exp_nreq);
`endif
        stream_valid_i = 1'b0;
        tick();
        tick();
        chk({tag, "_idle_req_valid"}, req_valid_o, 0);
    endtask

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h1000, 32'd256,  2, 15, 0, 32'h0,    -1};
        vecs[1] = '{32'h0FF0, 32'd64,   2,  1, 0, 32'h0,    -1};
        vecs[2] = '{32'h2000, 32'd0,    0,  0, 0, 32'h0,     2};
        vecs[3] = '{32'h1004, 32'd256,  0,  0, 1, 32'h1004,  2};
        vecs[4] = '{32'h3000, 32'd12,   0,  0, 1, 32'h3000,  2};
        vecs[5] = '{32'h0FF8, 32'd8,    1,  0, 0, 32'h0,    -1};
        vecs[6] = '{32'h0000, 32'd2048, 16, 15, 0, 32'h0,   -1};
        vecs[7] = '{32'h1FC8, 32'd128,  2,  6, 0, 32'h0,    -1};

        rst = 1'b1;
        stream_valid_i = 1'b0; desc_src_addr_i = '0; desc_num_bytes_i = '0;
        req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_err_i = 1'b0;
        ready_val = 1'b1; rsp_hold = 1'b0; err_rsp_at = -1;
        reset_counters();
        repeat (3) @(negedge clk);
        chk("reset_req_valid", req_valid_o, 0);
        chk("reset_done", stream_done_o, 0);
        chk("reset_err", stream_err_o, 0);
        chk("reset_req_addr", req_addr_o, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_desc(vecs[i], $sformatf("vec%0d", i));

        // Outstanding cap, then an error on the 2nd response.
        reset_counters();
        exp_q.delete();
        model_push(32'h1000, 32'd1024);
        ready_val = 1'b1; rsp_hold = 1'b1; err_rsp_at = 2;
        desc_src_addr_i = 32'h1000; desc_num_bytes_i = 32'd1024; stream_valid_i = 1'b1;
        repeat (12) tick();
        chk("cap_handshakes", nhs, 4);
        chk("cap_req_valid_low", req_valid_o, 0);
        ready_val = 1'b0; rsp_hold = 1'b0;
        for (int i = 0; i < 10 && nerr == 0; i++) tick();
        chk("rsp_err_count", nerr, 1);
        chk("rsp_err_addr", err_addr, 32'h1080);
        ready_val = 1'b1;
        for (int i = 0; i < 50 && ndone == 0; i++) tick();
        chk("rsp_err_done", ndone, 1);
        chk("rsp_err_no_more_req", nhs, 4);
        chk("rsp_err_rsp_total", rsp_idx, 4);
        chk("rsp_err_single_report", nerr, 1);
        stream_valid_i = 1'b0;
        tick(); tick();

        // Reset during ISSUE with two bursts outstanding.
        reset_counters();
        exp_q.delete();
        model_push(32'h1000, 32'd1024);
        ready_val = 1'b1; rsp_hold = 1'b1; err_rsp_at = -1;
        desc_src_addr_i = 32'h1000; desc_num_bytes_i = 32'd1024; stream_valid_i = 1'b1;
        for (int i = 0; i < 20 && nhs < 2; i++) tick();
        chk("pre_reset_handshakes", nhs, 2);
        rst = 1'b1;
        #1;
        chk("midrst_req_valid", req_valid_o, 0);
        chk("midrst_done", stream_done_o, 0);
        chk("midrst_err", stream_err_o, 0);
        chk("midrst_req_len", req_len_o, 0);
        stream_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        reset_counters();
        exp_q.delete();
        pend_rsp = 2; rsp_hold = 1'b0; err_rsp_at = 1;
        repeat (4) tick();
        chk("stale_rsp_no_err", nerr, 0);
        chk("stale_rsp_no_done", ndone, 0);
        chk("stale_rsp_no_req", nhs, 0);
        run_desc('{32'h2000, 32'd128, 1, 15, 0, 32'h0, -1}, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
